// File: rtl/spi_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_master                                                      |
// | Brief    : Mode-0 SPI initiator, one fixed-length word per cs_n window.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module spi_master #(
  parameter int CLKDIV = 4,
  parameter int WIDTH  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             cs_n,
  output logic             mosi,
  input  logic             miso
);

  localparam int c_DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int c_CNT_W = $clog2(WIDTH + 1);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLKDIV - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [c_DIV_W-1:0] r_div, w_div_nxt;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]   r_tx, w_tx_nxt;
  logic [WIDTH-1:0]   r_rx, w_rx_nxt;
  logic [WIDTH-1:0]   w_rx_data_nxt;
  logic               w_busy_nxt, w_done_nxt, w_sclk_nxt, w_cs_n_nxt, w_mosi_nxt;
  logic               w_div_end;
  logic [WIDTH-1:0]   w_tx_shift;
  logic [WIDTH-1:0]   w_rx_shift;

  assign w_div_end  = (r_div == c_DIV_LAST);
  assign w_tx_shift = r_tx << 1;

  // A one-bit word has nothing to keep from the previous shifter contents.
  generate
    if (WIDTH > 1) begin : g_rx_wide
      assign w_rx_shift = {r_rx[WIDTH-2:0], miso};
    end else begin : g_rx_single
      assign w_rx_shift = miso;
    end
  endgenerate

  always_comb begin
    w_state_nxt   = r_state;
    w_div_nxt     = r_div + c_DIV_W'(1);
    w_cnt_nxt     = r_cnt;
    w_tx_nxt      = r_tx;
    w_rx_nxt      = r_rx;
    w_rx_data_nxt = rx_data;
    w_busy_nxt    = busy;
    w_done_nxt    = 1'b0;
    w_sclk_nxt    = sclk;
    w_cs_n_nxt    = cs_n;
    w_mosi_nxt    = mosi;

    case (r_state)
      S_IDLE: begin
        w_div_nxt = '0;
        if (start) begin
          w_tx_nxt    = tx_data;
          w_rx_nxt    = '0;
          w_cnt_nxt   = '0;
          w_cs_n_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
          w_mosi_nxt  = tx_data[WIDTH-1];
          w_state_nxt = S_SETUP;
        end
      end

      S_SETUP, S_LOW: begin
        if (w_div_end) begin
          w_div_nxt   = '0;
          w_sclk_nxt  = 1'b1;
          w_state_nxt = S_HIGH;
        end
      end

      // miso is taken on the last cycle of the high phase, giving the
      // peripheral almost a full half-period to present its bit.
      S_HIGH: begin
        if (w_div_end) begin
          w_div_nxt  = '0;
          w_rx_nxt   = w_rx_shift;
          w_cnt_nxt  = r_cnt + c_CNT_W'(1);
          w_sclk_nxt = 1'b0;
          if (r_cnt == c_CNT_LAST) begin
            w_state_nxt = S_HOLD;
          end else begin
            w_tx_nxt    = w_tx_shift;
            w_mosi_nxt  = w_tx_shift[WIDTH-1];
            w_state_nxt = S_LOW;
          end
        end
      end

      S_HOLD: begin
        if (w_div_end) begin
          w_div_nxt     = '0;
          w_cs_n_nxt    = 1'b1;
          w_rx_data_nxt = r_rx;
          w_done_nxt    = 1'b1;
          w_busy_nxt    = 1'b0;
          w_mosi_nxt    = 1'b0;
          w_state_nxt   = S_IDLE;
        end
      end

      default: begin
        w_div_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_cnt   <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      rx_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      cs_n    <= 1'b1;
      mosi    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tx    <= w_tx_nxt;
      r_rx    <= w_rx_nxt;
      rx_data <= w_rx_data_nxt;
      busy    <= w_busy_nxt;
      done    <= w_done_nxt;
      sclk    <= w_sclk_nxt;
      cs_n    <= w_cs_n_nxt;
      mosi    <= w_mosi_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_spi_master                                                   |
// | Brief    : Directed bench for spi_master (CLKDIV=4 and CLKDIV=1 instances). |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_spi_master;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, miso, busy, done, sclk, cs_n, mosi;
  logic [7:0] tx_data, rx_data;
  logic       start1, miso1, busy1, done1, sclk1, cs_n1, mosi1;
  logic [7:0] tx_data1, rx_data1;
  int         miso_mode;
  logic       rand_miso;

  always_comb begin
    miso = rand_miso;
    case (miso_mode)
      0:       miso = mosi;
      1:       miso = 1'b1;
      2:       miso = 1'b0;
      default: miso = rand_miso;
    endcase
  end
  assign miso1 = mosi1;

  spi_master #(.CLKDIV(4), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data),
    .rx_data(rx_data), .busy(busy), .done(done), .sclk(sclk),
    .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  spi_master #(.CLKDIV(1), .WIDTH(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .tx_data(tx_data1),
    .rx_data(rx_data1), .busy(busy1), .done(done1), .sclk(sclk1),
    .cs_n(cs_n1), .mosi(mosi1), .miso(miso1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] tx;
    int         mode;        // 0 loopback, 1 miso=1, 2 miso=0
    int         restart_at;  // cycle of a second start pulse, -1 for none
    logic [7:0] exp_rx;
    logic [7:0] exp_bits;    // mosi seen at the rises, MSB first
    int         exp_done_cyc;
  } vec_t;

  vec_t vecs[5];

  task automatic run_xfer(input vec_t v);
    int         rises = 0, rise_err = 0, done_n = 0, done_cyc = -1;
    int         cs_falls = 0, idle_sclk = 0, mosi_glitch = 0, mosi_ones = 0;
    logic [7:0] bits = 8'h00, prev_rx, rx67 = 8'h00;
    logic       pcs = 1'b1, psclk = 1'b0, pmosi = 1'b0;
    miso_mode = v.mode;
    @(negedge clk);
    prev_rx = rx_data;
    start   = 1'b1;
    tx_data = v.tx;
    @(posedge clk);
    for (int c = 0; c < 76; c++) begin
      @(negedge clk);
      start = (c == v.restart_at - 1);
      if (start) tx_data = 8'h3C;
      if (c == 0) chk("accept_state", {cs_n, busy, mosi}, {1'b0, 1'b1, v.tx[7]});
      if (c == 67) rx67 = rx_data;
      if (sclk && !psclk) begin
        if (rises < 8) begin
          bits[7-rises] = mosi;
          if (c != 4 * (2 * rises + 1)) rise_err++;
        end
        rises++;
      end
      if (sclk && cs_n) idle_sclk++;
      if (sclk && psclk && mosi !== pmosi) mosi_glitch++;
      if (mosi) mosi_ones++;
      if (done) begin
        done_n++;
        done_cyc = c;
      end
      if (!cs_n && pcs) cs_falls++;
      pcs   = cs_n;
      psclk = sclk;
      pmosi = mosi;
    end
    chk("rise_count", rises, 8);
    chk("rise_times", rise_err, 0);
    chk("mosi_bits", bits, v.exp_bits);
    chk("mosi_stable_high", mosi_glitch, 0);
    chk("sclk_while_cs_high", idle_sclk, 0);
    chk("cs_windows", cs_falls, 1);
    chk("done_count", done_n, 1);
    chk("done_cycle", done_cyc, v.exp_done_cyc);
    chk("rx_hold_before_done", rx67, prev_rx);
    chk("rx_data", rx_data, v.exp_rx);
    if (v.tx == 8'h00) chk("mosi_zero", mosi_ones, 0);
  endtask

  initial begin
    int         dn, d1, d2, nd, hi;
    vec_t       post;

    vecs[0] = '{8'hA5, 0, -1, 8'hA5, 8'hA5, 68};
    vecs[1] = '{8'h00, 1, -1, 8'hFF, 8'h00, 68};
    vecs[2] = '{8'hFF, 2, -1, 8'h00, 8'hFF, 68};
    vecs[3] = '{8'hA5, 0, 20, 8'hA5, 8'hA5, 68};
    vecs[4] = '{8'h3C, 0, -1, 8'h3C, 8'h3C, 68};

    rst_n = 1'b0; start = 1'b0; start1 = 1'b0;
    tx_data = 8'h00; tx_data1 = 8'h00;
    miso_mode = 3; rand_miso = 1'b0;

    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_outputs", {cs_n, sclk, mosi, busy, done, rx_data},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
      start     = 1'($urandom);
      rand_miso = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_xfer(vecs[i]);

    // Reset mid-transfer: rx_data holds 3C from the previous word.
    miso_mode = 0;
    dn = 0;
    @(negedge clk);
    start   = 1'b1;
    tx_data = 8'h69;
    @(posedge clk);
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 29) rst_n = 1'b0;
      if (c == 30) begin
        chk("midreset_state", {cs_n, sclk, busy, done, rx_data},
            {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        rst_n = 1'b1;
      end
      if (done) dn++;
    end
    chk("midreset_no_done", dn, 0);
    post = '{8'h96, 0, -1, 8'h96, 8'h96, 68};
    run_xfer(post);

    // Back-to-back with start held high on the CLKDIV=1 instance.
    d1 = -1; d2 = -1; nd = 0; hi = 0;
    @(negedge clk);
    start1   = 1'b1;
    tx_data1 = 8'h5A;
    @(posedge clk);
    for (int c = 0; c < 37; c++) begin
      @(negedge clk);
      tx_data1 = 8'hC3;
      if (done1) begin
        if (nd == 0) begin
          d1 = c;
          chk("b2b_rx_first", rx_data1, 8'h5A);
        end else if (nd == 1) begin
          d2 = c;
        end
        nd++;
      end
      if (c >= 1 && c <= 34 && cs_n1) hi++;
    end
    chk("b2b_done_first", d1, 17);
    chk("b2b_done_second", d2, 35);
    chk("b2b_cs_high_cycles", hi, 1);
    chk("b2b_rx_second", rx_data1, 8'hC3);
    start1 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_master.md
# spi_master

Serial initiator that drives the other end of the lab's shift-register peripheral: it asserts chip select, generates the serial clock, shifts a parallel word out on MOSI (MSB first), and simultaneously captures MISO into a parallel receive word. It sits between on-board control logic (buttons/switches via input conditioners) and the peripheral's serial pins. Each transaction is a single fixed-length word framed by one chip-select window.

## Interface
- CLKDIV, 4: `clk` cycles per SCLK half-period; must be ≥ 1.
- WIDTH, 8: bits per transaction; must be ≥ 1.

- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a transaction; sampled only while busy=0.
- tx_data  input  WIDTH  word to transmit; latched on the accepting edge.
- rx_data  output  WIDTH  last fully received word; holds between transactions.
- busy  output  1  high while a transaction is in progress.
- done  output  1  one-cycle pulse when a transaction completes.
- sclk  output  1  serial clock; idles low.
- cs_n  output  1  chip select, active low; idles high.
- mosi  output  1  serial data out.
- miso  input  1  serial data in.

## Operation
- All outputs registered. Reset values: cs_n=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0; state=IDLE, counters cleared.
- States: IDLE, SETUP, HIGH, LOW, HOLD.
- IDLE: on edge with start=1, busy=0: latch tx_data into tx shifter, clear rx shifter and bit count; cs_n←0, busy←1, mosi←tx_data[WIDTH-1]; go SETUP.
- SETUP: CLKDIV cycles, sclk=0; at end sclk←1, go HIGH.
- HIGH: CLKDIV cycles, sclk=1. On its last cycle's edge: rx shifter ← {rx[WIDTH-2:0], miso}, bit count +1, sclk←0. If count reaches WIDTH go HOLD, else shift tx, mosi←next bit, go LOW.
- LOW: CLKDIV cycles, sclk=0; at end sclk←1, go HIGH.
- HOLD: CLKDIV cycles, sclk=0, cs_n=0. At end: cs_n←1, rx_data←rx shifter, done←1, busy←0, mosi←0; go IDLE.
- mosi changes only on the falling-SCLK edge or in SETUP; it is stable for the entire SCLK-high phase (mode 0). miso is sampled late in the high phase so the peripheral's conditioned-edge latency is absorbed.
- start while busy=1 is ignored and is not queued. start high during the done cycle is accepted (busy=0), so a new transaction starts on the next edge.
- rx_data updates only at transaction completion; never shows partial words.
- rst_n=0 at any edge, including mid-transaction, forces reset values on the next cycle. No done pulse is produced, and rx_data is cleared.

## Timing
- Cycle 0 is the edge accepting start. cs_n, busy, and mosi (MSB) are valid from cycle 0.
- The first sclk rise is at cycle CLKDIV. Rise k (k=0..WIDTH-1) is at CLKDIV·(2k+1), and the following fall is at CLKDIV·(2k+2).
- Exactly WIDTH SCLK rising edges per transaction; no SCLK activity while cs_n=1.
- cs_n rises, done pulses, and rx_data updates at cycle (2·WIDTH+1)·CLKDIV. With the defaults this is cycle 68.
- Minimum cs_n-high time between back-to-back transactions is 1 cycle.
- done is high for exactly 1 cycle.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with random start/miso. Required: cs_n=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0 throughout.
- Loopback miso=mosi, tx_data=8'hA5, defaults. Required: 8 sclk rises at cycles 4,12,…,60; mosi bits observed at the rises are 1,0,1,0,0,1,0,1; done at cycle 68; rx_data=8'hA5.
- miso tied 1, tx_data=8'h00. Required: mosi 0 throughout; rx_data=8'hFF; then miso tied 0 with tx_data=8'hFF gives rx_data=8'h00.
- start pulsed again at cycle 20 with tx_data=8'h3C. Required: a single cs_n-low window, one done at cycle 68, and rx_data equal to the first word only.
- rst_n=0 at cycle 30 of a transfer. Required: next cycle cs_n=1, sclk=0, busy=0, rx_data=0; no done ever; a following start runs a full correct transfer.
- start held high continuously, CLKDIV=1, loopback 8'h5A then 8'hC3. Required: done at cycle 17, cs_n high exactly 1 cycle, second done 18 cycles later, rx_data=8'hC3 after the second.
